// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO feeding a UART transmitter through a newd/dintx/donetx handshake. A byte written
// to an empty FIFO is presented one edge later. Writes while full are dropped and set a sticky overflow flag.
module uart_tx_fifo_feeder #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       newd,
  output logic [7:0]                 dintx,
  input  logic                       donetx,
  output logic                       busy,
  output logic                       sent
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DONE = 2'd1,
    S_WAIT_CLR  = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          donetx_q;
  logic          push;
  logic          pop;
  logic          rise;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign busy  = (state != S_IDLE);
  assign push  = wr_en && !full;
  assign pop   = (state == S_IDLE) && !empty;
  assign rise  = donetx && !donetx_q;

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      newd     <= 1'b0;
      dintx    <= 8'h00;
      sent     <= 1'b0;
      donetx_q <= 1'b0;
      state    <= S_IDLE;
    end else begin
      donetx_q <= donetx;
      sent     <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end

      if (push && !pop) begin
        level <= level + (AW+1)'(1);
      end else if (pop && !push) begin
        level <= level - (AW+1)'(1);
      end

      case (state)
        S_IDLE: begin
          if (pop) begin
            dintx  <= mem[rd_ptr];
            rd_ptr <= rd_ptr + AW'(1);
            newd   <= 1'b1;
            state  <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          // A donetx level already high on entry is not an acknowledge; only a fresh edge counts.
          if (rise) begin
            newd  <= 1'b0;
            sent  <= 1'b1;
            state <= S_WAIT_CLR;
          end
        end
        S_WAIT_CLR: begin
          if (!donetx) begin
            state <= S_IDLE;
          end
        end
        default: begin
          newd  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Directed bench for uart_tx_fifo_feeder: vector table for the basic handshake and burst,
// hand-written sequences for overflow, full-with-pop and reset mid-handshake.
module tb_uart_tx_fifo_feeder;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          newd;
  logic [7:0]    dintx;
  logic          donetx;
  logic          busy;
  logic          sent;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo_feeder #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .newd     (newd),
    .dintx    (dintx),
    .donetx   (donetx),
    .busy     (busy),
    .sent     (sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       donetx;
    logic       e_newd;
    logic [7:0] e_dintx;
    logic [4:0] e_level;
    logic       e_empty;
    logic       e_full;
    logic       e_sent;
    logic       e_busy;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Acknowledge the byte on the line, then expect the next byte to be presented.
  task automatic ack_then_expect(input logic [7:0] nxt);
    donetx = 1'b1;
    step();
    chk("ack_sent", sent, 1'b1);
    chk("ack_newd_low", newd, 1'b0);
    donetx = 1'b0;
    step();
    step();
    chk("next_newd", newd, 1'b1);
    chk("next_dintx", dintx, nxt);
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    donetx  = 1'b0;

    //              wr  data  dtx  newd dintx  lvl  emp full sent busy
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 8'h04, 1'b0, 1'b1, 8'h01, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    // donetx already high when the pop happens: must not count as an acknowledge
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[22] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 300; i++) step();
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_newd", newd, 1'b0);
    chk("rst_dintx", dintx, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sent", sent, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      wr_en   = vecs[i].wr_en;
      wr_data = vecs[i].wr_data;
      donetx  = vecs[i].donetx;
      step();
      chk($sformatf("v%0d_newd", i), newd, vecs[i].e_newd);
      chk($sformatf("v%0d_dintx", i), dintx, vecs[i].e_dintx);
      chk($sformatf("v%0d_level", i), level, vecs[i].e_level);
      chk($sformatf("v%0d_empty", i), empty, vecs[i].e_empty);
      chk($sformatf("v%0d_full", i), full, vecs[i].e_full);
      chk($sformatf("v%0d_sent", i), sent, vecs[i].e_sent);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d_overflow", i), overflow, 1'b0);
    end
    wr_en  = 1'b0;
    donetx = 1'b0;

    // Fill with no acknowledge: 0x10 is popped, 0x11..0x20 fill the FIFO, 0x21 is dropped.
    for (int i = 0; i < 17; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'h10 + 8'(i);
      step();
    end
    chk("fill_level", level, 16);
    chk("fill_full", full, 1'b1);
    chk("fill_no_ovf_yet", overflow, 1'b0);
    wr_data = 8'h21;
    step();
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_level", level, 16);
    chk("ovf_newd", newd, 1'b1);
    chk("ovf_dintx", dintx, 8'h10);
    wr_en = 1'b0;

    donetx = 1'b1;
    step();
    chk("full_ack_sent", sent, 1'b1);
    donetx = 1'b0;
    step();
    chk("full_idle_busy", busy, 1'b0);
    chk("full_idle_full", full, 1'b1);
    // Write lands on the same edge as the pop while still full: rejected.
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    chk("popfull_level", level, 15);
    chk("popfull_ovf", overflow, 1'b1);
    chk("popfull_dintx", dintx, 8'h11);
    chk("popfull_full", full, 1'b0);

    for (int b = 8'h12; b <= 8'h20; b++) begin
      ack_then_expect(8'(b));
    end
    donetx = 1'b1;
    step();
    chk("drain_sent", sent, 1'b1);
    donetx = 1'b0;
    step();
    step();
    chk("drain_empty", empty, 1'b1);
    chk("drain_level", level, 0);
    chk("drain_busy", busy, 1'b0);
    chk("drain_newd", newd, 1'b0);
    chk("drain_dintx_kept", dintx, 8'h20);

    // Reset in the middle of a handshake, with a write attempted during reset.
    wr_en   = 1'b1;
    wr_data = 8'h55;
    step();
    wr_en = 1'b0;
    step();
    chk("mid_newd", newd, 1'b1);
    chk("mid_dintx", dintx, 8'h55);
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h77;
    step();
    chk("midrst_newd", newd, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_empty", empty, 1'b1);
    chk("midrst_ovf", overflow, 1'b0);
    chk("midrst_dintx", dintx, 8'h00);
    wr_en = 1'b0;
    for (int i = 0; i < 20; i++) step();
    rst = 1'b0;
    step();
    chk("postrst_empty", empty, 1'b1);
    chk("postrst_newd", newd, 1'b0);
    wr_en   = 1'b1;
    wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    step();
    chk("post_newd", newd, 1'b1);
    chk("post_dintx", dintx, 8'h3C);
    donetx = 1'b1;
    step();
    chk("post_sent", sent, 1'b1);
    donetx = 1'b0;
    step();
    chk("post_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
